// File: rtl/song_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : song_sequencer_pkg
// Description : Shared FSM encoding, end-of-song terminator and the compiled-in
//               song image used by song_rom.
// Revision    : 1.0 - initial release
// ============================================================================
package song_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_CHECK = 3'd2,
        S_WAIT  = 3'd3,
        S_PAUSE = 3'd4,
        S_DONE  = 3'd5,
        S_END   = 3'd6
    } state_t;

    // A duration of zero marks the end of a song shorter than SONG_LEN.
    localparam int DUR_END = 0;

    // Song s (taken modulo 4) has a fixed length; song 1 fills every slot.
    function automatic int image_len(input int s, input int song_len);
        case (s % 4)
            0:       return 3;
            1:       return song_len;
            2:       return 5;
            default: return 2;
        endcase
    endfunction

    function automatic int image_note(input int s, input int i, input int song_len);
        if (i >= image_len(s, song_len)) return 0;
        case (s % 4)
            0:       return 10 + i;
            1:       return i + 1;
            2:       return 40 + i;
            default: return 60 + i;
        endcase
    endfunction

    function automatic int image_dur(input int s, input int i, input int song_len);
        if (i >= image_len(s, song_len)) return DUR_END;
        case (s % 4)
            0:       return 2 + i;
            1:       return i + 1;
            2:       return 7;
            default: return 3;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/song_sequencer_rom.sv
`default_nettype none
// ============================================================================
// Module      : song_rom
// Description : Synchronous song ROM, one-cycle read, word = {note, duration},
//               address = {song, idx}. An empty ROM_FILE builds a blank ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module song_rom
    import song_sequencer_pkg::*;
#(
    parameter string ROM_FILE  = "songs.mem",
    parameter int    NUM_SONGS = 4,
    parameter int    SONG_LEN  = 32,
    parameter int    NOTE_W    = 6,
    parameter int    DUR_W     = 6,
    localparam int   SONG_W    = $clog2(NUM_SONGS),
    localparam int   IDX_W     = $clog2(SONG_LEN),
    localparam int   ADDR_W    = SONG_W + IDX_W,
    localparam int   WIDTH     = NOTE_W + DUR_W
)(
    input  logic              clk,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [WIDTH-1:0]  o_data
);

    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] r_data;

    generate
        if (ROM_FILE == "") begin : g_blank
            // Every word is a terminator, so any song ends immediately.
            assign w_word = '0;
        end else begin : g_image
            int          w_song;
            int          w_idx;
            logic [31:0] w_note_v;
            logic [31:0] w_dur_v;

            always_comb begin
                w_song   = int'(i_addr[ADDR_W-1:IDX_W]);
                w_idx    = int'(i_addr[IDX_W-1:0]);
                w_note_v = 32'(image_note(w_song, w_idx, SONG_LEN));
                w_dur_v  = 32'(image_dur(w_song, w_idx, SONG_LEN));
                w_word   = {w_note_v[NOTE_W-1:0], w_dur_v[DUR_W-1:0]};
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        r_data <= w_word;
    end

    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/song_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : song_sequencer
// Description : Steps through the selected song one note at a time, handshaking
//               with note_player. Optional SONG_SEQ_LOOP_EN adds a loop input.
// Revision    : 1.0 - initial release
// ============================================================================
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int    NUM_SONGS = 4,
    parameter int    SONG_LEN  = 32,
    parameter int    NOTE_W    = 6,
    parameter int    DUR_W     = 6,
    parameter string ROM_FILE  = "songs.mem",
    localparam int   SONG_W    = $clog2(NUM_SONGS),
    localparam int   IDX_W     = $clog2(SONG_LEN)
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic [SONG_W-1:0] song,
    input  logic              note_done,
    output logic [NOTE_W-1:0] note,
    output logic [DUR_W-1:0]  duration,
    output logic              new_note,
    output logic              song_done
`ifdef SONG_SEQ_LOOP_EN
    ,
    input  logic              loop
`endif
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(SONG_LEN - 1);
    localparam logic [DUR_W-1:0] c_DUR_END  = DUR_W'(DUR_END);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [IDX_W-1:0]         r_idx;
    logic [IDX_W-1:0]         w_idx_nxt;
    logic [SONG_W-1:0]        r_cur_song;
    logic [SONG_W-1:0]        w_song_nxt;
    logic [NOTE_W-1:0]        r_note;
    logic [DUR_W-1:0]         r_duration;
    logic                     r_issue;
    logic                     r_new_note;
    logic                     r_song_done;
    logic                     w_abort;
    logic                     w_issue;
    logic                     w_loop;
    logic [NOTE_W+DUR_W-1:0]  w_rom_data;
    logic [NOTE_W-1:0]        w_rom_note;
    logic [DUR_W-1:0]         w_rom_dur;

`ifdef SONG_SEQ_LOOP_EN
    assign w_loop = loop;
`else
    assign w_loop = 1'b0;
`endif

    song_rom #(
        .ROM_FILE  (ROM_FILE),
        .NUM_SONGS (NUM_SONGS),
        .SONG_LEN  (SONG_LEN),
        .NOTE_W    (NOTE_W),
        .DUR_W     (DUR_W)
    ) u_rom (
        .clk    (clk),
        .i_addr ({r_cur_song, r_idx}),
        .o_data (w_rom_data)
    );

    assign w_rom_note = w_rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign w_rom_dur  = w_rom_data[DUR_W-1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_song_nxt  = r_cur_song;
        w_abort     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (play) begin
                    w_song_nxt  = song;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: w_state_nxt = S_CHECK;
            S_CHECK: begin
                w_state_nxt = (w_rom_dur == c_DUR_END) ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (note_done) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + 1'b1;
                        w_state_nxt = play ? S_FETCH : S_PAUSE;
                    end
                end
            end
            S_PAUSE: begin
                if (play) w_state_nxt = S_FETCH;
            end
            S_DONE: begin
                w_idx_nxt   = '0;
                w_state_nxt = (w_loop && play) ? S_FETCH : S_END;
            end
            S_END: begin
                if (!play) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // A new selection mid-song restarts it, overriding any note_done.
        if ((r_state == S_FETCH || r_state == S_CHECK ||
             r_state == S_WAIT  || r_state == S_PAUSE) && (song != r_cur_song)) begin
            w_abort     = 1'b1;
            w_idx_nxt   = '0;
            w_song_nxt  = song;
            w_state_nxt = play ? S_FETCH : S_IDLE;
        end

        w_issue = (r_state == S_CHECK) && (w_rom_dur != c_DUR_END) && !w_abort;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_cur_song  <= '0;
            r_note      <= '0;
            r_duration  <= '0;
            r_issue     <= 1'b0;
            r_new_note  <= 1'b0;
            r_song_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_cur_song <= w_song_nxt;
            if (w_issue) begin
                r_note     <= w_rom_note;
                r_duration <= w_rom_dur;
            end
            // The pulse trails the data by one cycle; an abort in between drops it.
            r_issue     <= w_issue;
            r_new_note  <= r_issue && (r_state == S_WAIT) && !w_abort;
            r_song_done <= (r_state == S_DONE);
        end
    end

    assign note      = r_note;
    assign duration  = r_duration;
    assign new_note  = r_new_note;
    assign song_done = r_song_done;

endmodule
`default_nettype wire

// File: tb/tb_song_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_song_sequencer
// Description : Scoreboard bench for song_sequencer (SONG_SEQ_LOOP_EN optional).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_song_sequencer;

    localparam int NS = 4;
    localparam int SL = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       play;
    logic [1:0] song;
    logic       note_done;
    logic [5:0] note;
    logic [5:0] duration;
    logic       new_note;
    logic       song_done;
`ifdef SONG_SEQ_LOOP_EN
    logic       loop;
`endif

    always #5 clk = ~clk;

    song_sequencer #(
        .NUM_SONGS (NS),
        .SONG_LEN  (SL),
        .NOTE_W    (6),
        .DUR_W     (6),
        .ROM_FILE  ("songs.mem")
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .song      (song),
        .note_done (note_done),
        .note      (note),
        .duration  (duration),
        .new_note  (new_note),
        .song_done (song_done)
`ifdef SONG_SEQ_LOOP_EN
        ,
        .loop      (loop)
`endif
    );

    typedef struct {
        bit is_done;
        int note;
        int dur;
    } ev_t;

    ev_t q[$];
    ev_t m_e;
    int  errors = 0;
    int  checks = 0;
    int  m_song;
    int  m_idx;
    int  tb_len  [NS];
    int  tb_note [NS][SL];
    int  tb_dur  [NS][SL];

    // Song contents as a plain table: length plus note/duration per slot.
    initial begin
        tb_len[0] = 3;  tb_len[1] = SL; tb_len[2] = 5; tb_len[3] = 2;
        for (int s = 0; s < NS; s++) begin
            for (int i = 0; i < SL; i++) begin
                tb_note[s][i] = 0;
                tb_dur[s][i]  = 0;
            end
        end
        for (int i = 0; i < 3; i++)  begin tb_note[0][i] = 10 + i; tb_dur[0][i] = 2 + i; end
        for (int i = 0; i < SL; i++) begin tb_note[1][i] = i + 1;  tb_dur[1][i] = i + 1; end
        for (int i = 0; i < 5; i++)  begin tb_note[2][i] = 40 + i; tb_dur[2][i] = 7;     end
        for (int i = 0; i < 2; i++)  begin tb_note[3][i] = 60 + i; tb_dur[3][i] = 3;     end
    end

    // Monitor: every output pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (new_note || song_done) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: new_note=%0b song_done=%0b note=%0d, required no pulse",
                         new_note, song_done, note);
            end else begin
                m_e = q.pop_front();
                if (new_note && song_done) begin
                    errors++;
                    $display("FAIL both_pulses: new_note and song_done high together, required one");
                end else if (m_e.is_done) begin
                    if (!song_done) begin
                        errors++;
                        $display("FAIL event_kind: got new_note note=%0d, required song_done", note);
                    end
                end else if (!new_note || int'(note) != m_e.note || int'(duration) != m_e.dur) begin
                    errors++;
                    $display("FAIL note_payload: got new=%0b note=%0d dur=%0d, required note=%0d dur=%0d",
                             new_note, note, duration, m_e.note, m_e.dur);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: the next event is the note at m_idx, or song end past the last one.
    task automatic expect_next();
        ev_t e;
        if (m_idx >= tb_len[m_song]) begin
            e.is_done = 1'b1; e.note = 0; e.dur = 0;
        end else begin
            e.is_done = 1'b0; e.note = tb_note[m_song][m_idx]; e.dur = tb_dur[m_song][m_idx];
        end
        q.push_back(e);
    endtask

    // Called just after the edge that sampled the trigger.
    task automatic wait_event(input bit want_note, input string name);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            tick();
            n++;
            if (new_note || song_done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: no pulse within %0d cycles, required one", name, n);
        end else if (want_note && (!new_note || n != 3)) begin
            errors++;
            $display("FAIL %s_latency: new_note=%0b after %0d edges, required new_note after 3", name, new_note, n);
        end else if (!want_note && !song_done) begin
            errors++;
            $display("FAIL %s_end: got new_note, required song_done", name);
        end
    endtask

    task automatic check_quiet(input int cycles, input string name);
        int p;
        p = 0;
        repeat (cycles) begin
            tick();
            if (new_note || song_done) p++;
        end
        checks++;
        if (p != 0) begin
            errors++;
            $display("FAIL %s: %0d pulses seen, required 0", name, p);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (note !== 6'd0 || duration !== 6'd0 || new_note !== 1'b0 || song_done !== 1'b0) begin
            errors++;
            $display("FAIL %s: note=%0d dur=%0d new_note=%0b song_done=%0b, required all 0",
                     name, note, duration, new_note, song_done);
        end
    endtask

    task automatic start(input int s);
        song   = 2'(s);
        play   = 1'b1;
        m_song = s;
        m_idx  = 0;
        expect_next();
        tick();
        wait_event(1'b1, "start");
    endtask

    task automatic answer(input int gap);
        repeat (gap) tick();
        note_done = 1'b1;
        m_idx++;
        expect_next();
        tick();
        note_done = 1'b0;
        wait_event(m_idx < tb_len[m_song], "advance");
    endtask

    // Pause while the note plays, finish it, then resume; only for non-last notes.
    task automatic pause_answer(input int gap);
        play = 1'b0;
        repeat (gap) tick();
        note_done = 1'b1;
        m_idx++;
        tick();
        note_done = 1'b0;
        check_quiet(6, "paused_quiet");
        play = 1'b1;
        expect_next();
        tick();
        wait_event(1'b1, "resume");
    endtask

    task automatic finish_song();
        check_quiet(10, "end_no_replay");
        play = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        reset     = 1'b1;
        play      = 1'b0;
        song      = 2'd0;
        note_done = 1'b0;
`ifdef SONG_SEQ_LOOP_EN
        loop      = 1'b0;
`endif
        repeat (3) tick();
        check_zero("reset_state");
        reset = 1'b0;
        tick();
        check_zero("idle_state");

        // Three-note song, each note answered 5 cycles later.
        start(0);
        while (m_idx < tb_len[m_song]) answer(5);
        finish_song();

        // Pause during note 2.
        start(0);
        answer(3);
        pause_answer(4);
        while (m_idx < tb_len[m_song]) answer(2);
        finish_song();

        // Switch 0 -> 2 in WAIT with a coincident note_done.
        start(0);
        repeat (2) tick();
        song      = 2'd2;
        note_done = 1'b1;
        m_song    = 2;
        m_idx     = 0;
        expect_next();
        tick();
        note_done = 1'b0;
        wait_event(1'b1, "switch");
        while (m_idx < tb_len[m_song]) answer(2);
        finish_song();

        // Reset mid-song, then replay the full-length song from the start.
        start(1);
        answer(2);
        answer(3);
        reset = 1'b1;
        play  = 1'b0;
        tick();
        check_zero("midsong_reset");
        reset = 1'b0;
        tick();
        check_quiet(4, "post_reset_idle");
        start(1);
        while (m_idx < tb_len[m_song]) answer(int'($urandom_range(1, 3)));
        finish_song();

        // Randomised songs, gaps and pauses.
        for (int k = 0; k < 6; k++) begin
            start(int'($urandom_range(0, NS - 1)));
            while (m_idx < tb_len[m_song]) begin
                if (m_idx + 1 < tb_len[m_song] && $urandom_range(0, 3) == 0)
                    pause_answer(int'($urandom_range(1, 4)));
                else
                    answer(int'($urandom_range(1, 6)));
            end
            finish_song();
        end

`ifdef SONG_SEQ_LOOP_EN
        // Loop: song end pulses song_done and restarts without toggling play.
        loop = 1'b1;
        start(3);
        answer(3);
        repeat (2) tick();
        note_done = 1'b1;
        m_idx++;
        expect_next();
        m_idx = 0;
        expect_next();
        tick();
        note_done = 1'b0;
        wait_event(1'b0, "loop_done");
        wait_event(1'b1, "loop_restart");
        loop = 1'b0;
        while (m_idx < tb_len[m_song]) answer(2);
        finish_song();
`endif

        repeat (5) tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover_events: %0d expected events never seen, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
Parametrised successor to the single-ROM song reader. Stores NUM_SONGS songs of up to SONG_LEN {note, duration} entries in a synchronous ROM and steps through the selected song one note at a time, handshaking with the note player via new_note/note_done. Adds a zero-duration end-of-song terminator, mid-song song switching, pause/resume without losing position, and an optional loop mode. It sits between the top-level user controls (play, song select) and note_player.

Parameters:
NUM_SONGS, 4, number of songs; SONG_W = clog2(NUM_SONGS)
SONG_LEN, 32, maximum notes per song; IDX_W = clog2(SONG_LEN)
NOTE_W, 6, width of the note code
DUR_W, 6, width of the duration field
ROM_FILE, "songs.mem", $readmemb image; word = {note, duration}, address = {song, idx}

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
play  in  1  level: 1 = run, 0 = pause
song  in  SONG_W  song select
note_done  in  1  one-cycle pulse from note_player: current note finished
note  out  NOTE_W  current note code, held between new_note pulses
duration  out  DUR_W  current duration, held between new_note pulses
new_note  out  1  one-cycle pulse: note/duration are valid and new
song_done  out  1  one-cycle pulse: song has ended
loop  in  1  present only with SONG_SEQ_LOOP_EN: restart the song at its end

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE, idx=0, cur_song=0, note=0, duration=0, new_note=0, song_done=0. Reset overrides every other input in the same cycle, including mid-song.
- States:
  - IDLE: when play=1, latch cur_song=song and go to FETCH.
  - FETCH: present ROM address {cur_song, idx}. ROM read latency is 1 cycle. Go to CHECK.
  - CHECK:
    - If the ROM duration field is 0, go to DONE; no new_note is issued.
    - Otherwise register note/duration, pulse new_note next cycle, go to WAIT.
  - WAIT: on note_done=1:
    - If idx==SONG_LEN-1, go to DONE.
    - Otherwise idx=idx+1; go to FETCH if play=1, else go to PAUSE.
  - PAUSE: hold idx; go to FETCH when play=1.
  - DONE: pulse song_done for 1 cycle, set idx=0, go to END.
  - END: wait for play=0, then go to IDLE. This prevents auto-replay.
- Latency: new_note is high exactly 3 rising edges after the edge that samples play=1 in IDLE. The same holds after WAIT→FETCH: 3 edges after note_done is sampled.
- Pause in WAIT: stay in WAIT and still accept note_done (note_player finishes the current note). Advance goes to PAUSE if play=0.
- Song change: if song!=cur_song while in FETCH, CHECK, WAIT or PAUSE:
  - Abort immediately: idx=0, cur_song=song, go to FETCH (if play=1) else IDLE.
  - No song_done for the aborted song.
  - This takes priority over a coincident note_done.
- note_done outside WAIT is ignored.
- idx never wraps silently. The last index always routes to DONE.
- new_note and song_done are never high in the same cycle.

Optional Feature:
SONG_SEQ_LOOP_EN
- Defined: adds the loop port. In DONE, if loop=1, song_done still pulses, idx=0, next state is FETCH (skips END). The song replays while play=1.
- Undefined: no loop port; DONE always goes to END.

Decomposition:
- song_defs.vh holds: state encodings (IDLE, FETCH, CHECK, WAIT, PAUSE, DONE, END; 3 bits) and the DUR_END=0 terminator constant.
- Sub-module song_rom (synchronous ROM, parameters ROM_FILE/depth/width, 1-cycle read). The FSM and index counter stay in song_sequencer.

Test Plan:
- Reset, then play=1, song=0; ROM song0 = 3 notes then dur 0 -> new_note at +3 edges with note/duration = ROM[0]. Answer each note with note_done 5 cycles later -> 3 new_note pulses, one song_done, then END; no further pulses while play stays 1.
- Full-length song (SONG_LEN entries, no terminator) -> song_done after the 32nd note_done; idx returns to 0.
- Pause: play=0 during note 2 (WAIT), note_done given -> no new_note. play=1 -> new_note carries note 3 after 3 edges.
- Switch song 0->2 in WAIT with coincident note_done -> restart at ROM[{2,0}], no song_done.
- Reset asserted mid-song -> next cycle all outputs 0, state IDLE. Replay starts from idx 0.
- With SONG_SEQ_LOOP_EN, loop=1: 3-note song -> song_done pulse, then new_note for ROM[{song,0}] 3 edges later, without play toggling.
